// File: rtl/cache_pkg.sv
// Shared geometry constants and the operation-mode encoding for the direct-mapped cache core.
package cache_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned TAG_W   = 5;
  localparam int unsigned INDEX_W = 4;
  localparam int unsigned WORD_W  = 2;
  localparam int unsigned LINES   = 2 ** INDEX_W;
  localparam int unsigned WORDS   = 2 ** WORD_W;

  typedef enum logic [1:0] {CMP_RD, CMP_WR, ACC_RD, ACC_WR} cache_mode_e;

  function automatic cache_mode_e decode_mode(input logic cmp, input logic write);
    if (cmp) return write ? CMP_WR : CMP_RD;
    return write ? ACC_WR : ACC_RD;
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// One cache line: tag, valid and dirty metadata plus a small word array, all cleared asynchronously.
module cache_line_store #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned WORD_W = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                word_we_i,
  input  logic [WORD_W-1:0]                   word_sel_i,
  input  logic [DATA_W-1:0]                   wdata_i,
  input  logic                                meta_we_i,
  input  logic [TAG_W-1:0]                    tag_i,
  input  logic                                valid_i,
  input  logic                                dirty_i,
  output logic [TAG_W-1:0]                    tag_o,
  output logic                                valid_o,
  output logic                                dirty_o,
  output logic [2**WORD_W-1:0][DATA_W-1:0]    words_o
);

  logic [TAG_W-1:0]                 tag_q;
  logic                             valid_q;
  logic                             dirty_q;
  logic [2**WORD_W-1:0][DATA_W-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q   <= '0;
      valid_q <= 1'b0;
      dirty_q <= 1'b0;
      data_q  <= '0;
    end else begin
      if (meta_we_i) begin
        tag_q   <= tag_i;
        valid_q <= valid_i;
        dirty_q <= dirty_i;
      end
      if (word_we_i) data_q[word_sel_i] <= wdata_i;
    end
  end

  assign tag_o   = tag_q;
  assign valid_o = valid_q;
  assign dirty_o = dirty_q;
  assign words_o = data_q;

endmodule

// File: rtl/cache_core.sv
// Direct-mapped cache data/tag array: index decode, tag compare, output muxing and write enables
// over sixteen line stores. Lookups are combinational; updates commit on the rising edge.
module cache_core
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [INDEX_W-1:0] index,
  input  logic [WORD_W-1:0]  word,
  input  logic               cmp,
  input  logic               write,
  input  logic [TAG_W-1:0]   tag,
  input  logic [DATA_W-1:0]  data_in,
  input  logic               valid_in,
  input  logic               dirty_in,
  output logic               hit,
  output logic               dirty,
  output logic [TAG_W-1:0]   tag_out,
  output logic [DATA_W-1:0]  data_out,
  output logic               valid
);

  logic [TAG_W-1:0]             line_tag   [LINES];
  logic                         line_valid [LINES];
  logic                         line_dirty [LINES];
  logic [WORDS-1:0][DATA_W-1:0] line_words [LINES];

  logic [LINES-1:0] word_we;
  logic [LINES-1:0] meta_we;
  logic [TAG_W-1:0] tag_d;
  logic             valid_d;
  logic             dirty_d;
  logic             match;

  for (genvar i = 0; i < LINES; i++) begin : g_line
    cache_line_store #(
      .DATA_W (DATA_W),
      .TAG_W  (TAG_W),
      .WORD_W (WORD_W)
    ) u_line (
      .clk        (clk),
      .rst_n      (rst_n),
      .word_we_i  (word_we[i]),
      .word_sel_i (word),
      .wdata_i    (data_in),
      .meta_we_i  (meta_we[i]),
      .tag_i      (tag_d),
      .valid_i    (valid_d),
      .dirty_i    (dirty_d),
      .tag_o      (line_tag[i]),
      .valid_o    (line_valid[i]),
      .dirty_o    (line_dirty[i]),
      .words_o    (line_words[i])
    );
  end

  assign match = line_valid[index] & (line_tag[index] == tag);

  always_comb begin
    hit      = 1'b0;
    dirty    = 1'b0;
    valid    = 1'b0;
    tag_out  = '0;
    data_out = '0;
    word_we  = '0;
    meta_we  = '0;
    tag_d    = tag;
    valid_d  = valid_in;
    dirty_d  = dirty_in;
    // Mode is only decoded when enabled so cmp/write are don't-care while idle.
    if (enable) begin
      dirty    = line_dirty[index];
      valid    = line_valid[index];
      tag_out  = line_tag[index];
      data_out = line_words[index][word];
      unique case (decode_mode(cmp, write))
        CMP_RD: hit = match;
        CMP_WR: begin
          hit = match;
          if (match) begin
            // Hit write keeps tag/valid and marks the line dirty.
            word_we[index] = 1'b1;
            meta_we[index] = 1'b1;
            tag_d          = line_tag[index];
            valid_d        = 1'b1;
            dirty_d        = 1'b1;
          end
        end
        ACC_RD: hit = 1'b0;
        ACC_WR: begin
          word_we[index] = 1'b1;
          meta_we[index] = 1'b1;
        end
        default: hit = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_core.sv
// Directed and randomized checks of cache_core against an array-based reference model.
module tb_cache_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [3:0]  index;
  logic [1:0]  word;
  logic        cmp;
  logic        write;
  logic [4:0]  tag;
  logic [15:0] data_in;
  logic        valid_in;
  logic        dirty_in;
  logic        hit;
  logic        dirty;
  logic [4:0]  tag_out;
  logic [15:0] data_out;
  logic        valid;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: plain arrays indexed by line and word.
  bit        m_valid [16];
  bit        m_dirty [16];
  bit [4:0]  m_tag   [16];
  bit [15:0] m_data  [16][4];

  always #5 clk = ~clk;

  cache_core dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .index    (index),
    .word     (word),
    .cmp      (cmp),
    .write    (write),
    .tag      (tag),
    .data_in  (data_in),
    .valid_in (valid_in),
    .dirty_in (dirty_in),
    .hit      (hit),
    .dirty    (dirty),
    .tag_out  (tag_out),
    .data_out (data_out),
    .valid    (valid)
  );

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
      for (int w = 0; w < 4; w++) m_data[i][w] = '0;
    end
  endtask

  task automatic check_outputs(input bit en, input bit c, input bit [3:0] idx, input bit [1:0] wd,
                               input bit [4:0] tg);
    bit exp_hit;
    exp_hit = en && c && m_valid[idx] && (m_tag[idx] == tg);
    check_eq("hit",      32'(hit),      32'(exp_hit));
    check_eq("dirty",    32'(dirty),    en ? 32'(m_dirty[idx]) : 32'd0);
    check_eq("valid",    32'(valid),    en ? 32'(m_valid[idx]) : 32'd0);
    check_eq("tag_out",  32'(tag_out),  en ? 32'(m_tag[idx]) : 32'd0);
    check_eq("data_out", 32'(data_out), en ? 32'(m_data[idx][wd]) : 32'd0);
  endtask

  // One clocked operation: drive at negedge, check pre-edge outputs, update model at posedge.
  task automatic op(input bit en, input bit c, input bit w, input bit [3:0] idx,
                    input bit [1:0] wd, input bit [4:0] tg, input bit [15:0] d,
                    input bit vi, input bit di);
    @(negedge clk);
    enable   = en;
    cmp      = c;
    write    = w;
    index    = idx;
    word     = wd;
    tag      = tg;
    data_in  = d;
    valid_in = vi;
    dirty_in = di;
    #2;
    check_outputs(en, c, idx, wd, tg);
    @(posedge clk);
    if (en && w) begin
      if (c) begin
        if (m_valid[idx] && m_tag[idx] == tg) begin
          m_data[idx][wd] = d;
          m_dirty[idx]    = 1'b1;
        end
      end else begin
        m_data[idx][wd] = d;
        m_tag[idx]      = tg;
        m_valid[idx]    = vi;
        m_dirty[idx]    = di;
      end
    end
  endtask

  // Combinational look at one line without waiting for a clock edge.
  task automatic peek(input bit [3:0] idx, input bit [1:0] wd);
    enable = 1'b1;
    cmp    = 1'b0;
    write  = 1'b0;
    index  = idx;
    word   = wd;
    #1;
    check_outputs(1'b1, 1'b0, idx, wd, tag);
  endtask

  initial begin
    bit [3:0]  r_idx;
    bit [4:0]  r_tag;
    rst_n    = 1'b0;
    enable   = 1'b0;
    cmp      = 1'b0;
    write    = 1'b0;
    index    = '0;
    word     = '0;
    tag      = '0;
    data_in  = '0;
    valid_in = 1'b0;
    dirty_in = 1'b0;
    model_clear();

    // Reset state: every line invalid and clean.
    #3;
    for (int i = 0; i < 16; i++) peek(4'(i), 2'(i));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    op(1, 1, 0, 4'd7, 2'd2, 5'd0, 16'h0, 0, 0);

    // Access write then compare read.
    op(1, 0, 1, 4'd0, 2'd3, 5'b11101, 16'h0F0F, 1, 0);
    op(1, 1, 0, 4'd0, 2'd3, 5'b11101, 16'h0, 0, 0);
    // Compare write hit marks dirty; other words untouched.
    op(1, 1, 1, 4'd0, 2'd1, 5'b11101, 16'hBEEF, 0, 0);
    op(1, 1, 0, 4'd0, 2'd1, 5'b11101, 16'h0, 0, 0);
    op(1, 1, 0, 4'd0, 2'd3, 5'b11101, 16'h0, 0, 0);
    // Compare write miss leaves the array alone.
    op(1, 1, 1, 4'd0, 2'd1, 5'b00001, 16'h1234, 0, 0);
    op(1, 0, 0, 4'd0, 2'd1, 5'b00001, 16'h0, 0, 0);
    // Access write with valid_in=0 prevents a hit.
    op(1, 0, 1, 4'd5, 2'd0, 5'b01010, 16'hA5A5, 0, 1);
    op(1, 1, 0, 4'd5, 2'd0, 5'b01010, 16'h0, 0, 0);
    // Idle cycle with unknown mode inputs: outputs zero, no update.
    @(negedge clk);
    enable  = 1'b0;
    cmp     = 1'bx;
    write   = 1'bx;
    index   = 4'd0;
    word    = 2'd1;
    tag     = 5'b11101;
    data_in = 16'hDEAD;
    #2;
    check_outputs(0, 0, 4'd0, 2'd1, 5'b11101);
    @(posedge clk);
    op(1, 1, 0, 4'd0, 2'd1, 5'b11101, 16'h0, 0, 0);

    // Randomized traffic, tags biased toward stored ones to produce hits.
    for (int n = 0; n < 400; n++) begin
      r_idx = 4'($urandom_range(0, 15));
      r_tag = ($urandom_range(0, 1) == 1) ? m_tag[r_idx] : 5'($urandom);
      op(($urandom_range(0, 9) != 0), 1'($urandom), 1'($urandom), r_idx, 2'($urandom), r_tag,
         16'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom));
    end

    // Fill every line, then assert reset mid-cycle and check it clears before any edge.
    for (int i = 0; i < 16; i++)
      op(1, 0, 1, 4'(i), 2'(i), 5'(i + 3), 16'(16'h1000 + i), 1, 1);
    @(negedge clk);
    enable = 1'b1;
    cmp    = 1'b0;
    write  = 1'b1;
    index  = 4'd9;
    data_in = 16'hFFFF;
    #1;
    rst_n = 1'b0;
    model_clear();
    peek(4'd9, 2'd1);
    for (int i = 0; i < 16; i++) peek(4'(i), 2'(i));
    @(negedge clk);
    rst_n = 1'b1;
    op(1, 1, 0, 4'd3, 2'd3, 5'd6, 16'h0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
